// File: rtl/register_file_sb_if.sv
// Register file bus: two read ports, one byte-enabled write port,
// reserve port, operand busy flags and pending count.
//   master: drives A1/A2/A3/WD3/WE/BE/RSV/RA, observes RD*/BUSY*/PEND_CNT
//   slave : the register file itself
interface register_file_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0]   A1;
    logic [ADDR_W-1:0]   A2;
    logic [DATA_W-1:0]   RD1;
    logic [DATA_W-1:0]   RD2;
    logic [ADDR_W-1:0]   A3;
    logic [DATA_W-1:0]   WD3;
    logic                WE;
    logic [DATA_W/8-1:0] BE;
    logic                RSV;
    logic [ADDR_W-1:0]   RA;
    logic                BUSY1;
    logic                BUSY2;
    logic [ADDR_W:0]     PEND_CNT;

    modport master (
        output A1, A2, A3, WD3, WE, BE, RSV, RA,
        input  RD1, RD2, BUSY1, BUSY2, PEND_CNT
    );

    modport slave (
        input  A1, A2, A3, WD3, WE, BE, RSV, RA,
        output RD1, RD2, BUSY1, BUSY2, PEND_CNT
    );
endinterface

// File: rtl/register_file_sb.sv
// Register file with per-register pending scoreboard.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (data, pending bits, count)
//   bus  : slave side of register_file_sb_if (reads, write, reserve, busy, count)
module register_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic               clk,
    input logic               rst,
    register_file_sb_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_d;

    logic [DATA_W-1:0] be_mask;
    logic [DATA_W-1:0] wr_word;
    logic              wr_ok;
    logic              rsv_ok;
    logic              inc;
    logic              dec;
    logic              zero1;
    logic              zero2;
    logic              hit1;
    logic              hit2;

    always_comb begin
        be_mask = '0;
        for (int b = 0; b < NB; b++) begin
            be_mask[b*8 +: 8] = {8{bus.BE[b]}};
        end
    end

    // Register 0 is neither writable nor reservable when hardwired.
    assign wr_ok  = !rst && bus.WE
                    && !((ZERO_REG != 0) && (bus.A3 == '0));
    assign rsv_ok = !rst && bus.RSV
                    && !((ZERO_REG != 0) && (bus.RA == '0));

    // Stored word with the enabled bytes replaced; used for both
    // the write itself and same-cycle forwarding.
    assign wr_word = (mem_q[bus.A3] & ~be_mask)
                   | (bus.WD3 & be_mask);

    // Set is applied after clear so a same-address reserve wins.
    always_comb begin
        pend_d = pend_q;
        if (wr_ok) begin
            pend_d[bus.A3] = 1'b0;
        end
        if (rsv_ok) begin
            pend_d[bus.RA] = 1'b1;
        end
    end

    // Count only real transitions: a clear overridden by a set on
    // the same address is not a clear.
    assign inc = rsv_ok && !pend_q[bus.RA];
    assign dec = wr_ok && pend_q[bus.A3]
                 && !(rsv_ok && (bus.RA == bus.A3));

    assign cnt_d = cnt_q
                 + (ADDR_W+1)'(inc)
                 - (ADDR_W+1)'(dec);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_ok) begin
                mem_q[bus.A3] <= wr_word;
            end
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign zero1 = (ZERO_REG != 0) && (bus.A1 == '0);
    assign zero2 = (ZERO_REG != 0) && (bus.A2 == '0);
    assign hit1  = (BYPASS != 0) && wr_ok && (bus.A1 == bus.A3);
    assign hit2  = (BYPASS != 0) && wr_ok && (bus.A2 == bus.A3);

    assign bus.RD1 = zero1 ? '0 : (hit1 ? wr_word : mem_q[bus.A1]);
    assign bus.RD2 = zero2 ? '0 : (hit2 ? wr_word : mem_q[bus.A2]);

    // A forwarded write already supplies the operand, so not busy.
    assign bus.BUSY1 = !zero1 && !hit1 && pend_q[bus.A1];
    assign bus.BUSY2 = !zero2 && !hit2 && pend_q[bus.A2];

    assign bus.PEND_CNT = cnt_q;
endmodule

// File: tb/tb_register_file_sb.sv
// Testbench for register_file_sb: BYPASS=1 and BYPASS=0 instances
// driven in parallel and checked against a behavioural model.
module tb_register_file_sb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  a1 = '0, a2 = '0, a3 = '0, ra = '0;
    logic [31:0] wd3 = '0;
    logic        we = 1'b0, rsv = 1'b0;
    logic [3:0]  be = '0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_mem [32];
    bit          m_pend [32];

    always #5 clk = ~clk;

    register_file_sb_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
    register_file_sb_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();

    assign bus1.A1 = a1;  assign bus0.A1 = a1;
    assign bus1.A2 = a2;  assign bus0.A2 = a2;
    assign bus1.A3 = a3;  assign bus0.A3 = a3;
    assign bus1.WD3 = wd3; assign bus0.WD3 = wd3;
    assign bus1.WE = we;  assign bus0.WE = we;
    assign bus1.BE = be;  assign bus0.BE = be;
    assign bus1.RSV = rsv; assign bus0.RSV = rsv;
    assign bus1.RA = ra;  assign bus0.RA = ra;

    register_file_sb #(.BYPASS(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );
    register_file_sb #(.BYPASS(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        logic [31:0] w;
        if (a == 0) return 32'h0;
        w = m_mem[a];
        if (byp && we && !rst && a == a3)
            for (int b = 0; b < 4; b++)
                if (be[b]) w[b*8 +: 8] = wd3[b*8 +: 8];
        return w;
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && we && !rst && a == a3) return 1'b0;
        return m_pend[a];
    endfunction

    // Apply this cycle's inputs to the model, then advance the DUTs.
    task automatic tick();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i] = '0;
                m_pend[i] = 0;
            end
        end else begin
            if (we && a3 != 0) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) m_mem[a3][b*8 +: 8] = wd3[b*8 +: 8];
                m_pend[a3] = 0;
            end
            if (rsv && ra != 0) m_pend[ra] = 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        we = 0; rsv = 0; be = '0;
    endtask

    task automatic test_reset();
        rst = 1; we = 1; a3 = 5'd5; wd3 = $urandom; be = 4'hF;
        rsv = 1; ra = 5'd6;
        tick();
        rst = 0; idle();
        a1 = 5'd5; a2 = 5'd31;
        #1;
        n_cmp++;
        if (bus1.RD1 !== 0 || bus1.RD2 !== 0 || bus0.RD1 !== 0 || bus0.RD2 !== 0) begin
            n_bad++;
            $display("FAIL reset_rd: rd1=%h rd2=%h want 0", bus1.RD1, bus1.RD2);
        end
        n_cmp++;
        if (bus1.BUSY1 !== 0 || bus1.BUSY2 !== 0 || bus1.PEND_CNT !== 0) begin
            n_bad++;
            $display("FAIL reset_busy: b1=%b b2=%b cnt=%0d want 0 0 0",
                     bus1.BUSY1, bus1.BUSY2, bus1.PEND_CNT);
        end
        for (int a = 0; a < 32; a++) begin
            a1 = 5'(a); a2 = 5'(31 - a);
            #1;
            n_cmp++;
            if (bus1.RD1 !== 0 || bus0.RD2 !== 0 || bus1.BUSY1 !== 0 || bus0.BUSY2 !== 0) begin
                n_bad++;
                $display("FAIL reset_addr%0d: rd=%h busy=%b want 0", a, bus1.RD1, bus1.BUSY1);
            end
        end
    endtask

    task automatic test_byte_write();
        we = 1; a3 = 5'd7; wd3 = 32'hDEADBEEF; be = 4'b1111;
        tick();
        we = 1; a3 = 5'd7; wd3 = 32'h000000AA; be = 4'b0001;
        tick();
        idle(); a1 = 5'd7; a2 = 5'd7;
        #1;
        n_cmp++;
        if (bus1.RD1 !== 32'hDEADBEAA || bus0.RD2 !== 32'hDEADBEAA) begin
            n_bad++;
            $display("FAIL byte_write: got %h/%h want deadbeaa", bus1.RD1, bus0.RD2);
        end
        we = 1; a3 = 5'd7; wd3 = 32'h12345678; be = 4'b0000;
        tick();
        idle();
        #1;
        n_cmp++;
        if (bus1.RD1 !== 32'hDEADBEAA) begin
            n_bad++;
            $display("FAIL be_zero: got %h want deadbeaa", bus1.RD1);
        end
    endtask

    task automatic test_bypass();
        we = 1; a3 = 5'd9; wd3 = 32'h11111111; be = 4'hF;
        tick();
        we = 1; a3 = 5'd9; wd3 = 32'h12345678; be = 4'hF; a1 = 5'd9;
        #1;
        n_cmp++;
        if (bus1.RD1 !== 32'h12345678) begin
            n_bad++;
            $display("FAIL bypass_on: got %h want 12345678", bus1.RD1);
        end
        n_cmp++;
        if (bus0.RD1 !== 32'h11111111) begin
            n_bad++;
            $display("FAIL bypass_off_old: got %h want 11111111", bus0.RD1);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (bus0.RD1 !== 32'h12345678) begin
            n_bad++;
            $display("FAIL bypass_off_new: got %h want 12345678", bus0.RD1);
        end
    endtask

    task automatic test_zero_reg();
        we = 1; a3 = 5'd0; wd3 = 32'hFFFFFFFF; be = 4'hF;
        rsv = 1; ra = 5'd0; a1 = 5'd0;
        #1;
        n_cmp++;
        if (bus1.RD1 !== 0 || bus1.BUSY1 !== 0) begin
            n_bad++;
            $display("FAIL zero_same: rd=%h busy=%b want 0 0", bus1.RD1, bus1.BUSY1);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (bus1.RD1 !== 0 || bus0.RD1 !== 0 || bus1.BUSY1 !== 0 || bus1.PEND_CNT !== 0) begin
            n_bad++;
            $display("FAIL zero_after: rd=%h busy=%b cnt=%0d want 0 0 0",
                     bus1.RD1, bus1.BUSY1, bus1.PEND_CNT);
        end
    endtask

    task automatic test_pending();
        rsv = 1; ra = 5'd3; tick();
        rsv = 1; ra = 5'd4; tick();
        idle(); a1 = 5'd3;
        #1;
        n_cmp++;
        if (bus1.PEND_CNT !== 2 || bus1.BUSY1 !== 1) begin
            n_bad++;
            $display("FAIL pend_two: cnt=%0d busy=%b want 2 1", bus1.PEND_CNT, bus1.BUSY1);
        end
        rsv = 1; ra = 5'd3; tick();
        idle();
        #1;
        n_cmp++;
        if (bus1.PEND_CNT !== 2) begin
            n_bad++;
            $display("FAIL pend_rerv: cnt=%0d want 2", bus1.PEND_CNT);
        end
        we = 1; a3 = 5'd3; wd3 = 32'hA5A5A5A5; be = 4'hF; tick();
        idle();
        #1;
        n_cmp++;
        if (bus1.PEND_CNT !== 1 || bus1.BUSY1 !== 0) begin
            n_bad++;
            $display("FAIL pend_clr: cnt=%0d busy=%b want 1 0", bus1.PEND_CNT, bus1.BUSY1);
        end
        we = 1; a3 = 5'd4; wd3 = 32'h0BADF00D; be = 4'hF;
        rsv = 1; ra = 5'd4; tick();
        idle(); a1 = 5'd4;
        #1;
        n_cmp++;
        if (bus1.PEND_CNT !== 1 || bus1.BUSY1 !== 1 || bus1.RD1 !== 32'h0BADF00D) begin
            n_bad++;
            $display("FAIL set_wins: cnt=%0d busy=%b rd=%h want 1 1 0badf00d",
                     bus1.PEND_CNT, bus1.BUSY1, bus1.RD1);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 10; i++) begin
            rsv = 1; ra = 5'(i + 10); tick();
        end
        idle();
        #1;
        n_cmp++;
        if (int'(bus1.PEND_CNT) != m_cnt()) begin
            n_bad++;
            $display("FAIL pend_ten: cnt=%0d want %0d", bus1.PEND_CNT, m_cnt());
        end
        rst = 1; rsv = 1; ra = 5'd12; tick();
        rst = 0; idle();
        for (int a = 0; a < 32; a++) begin
            a1 = 5'(a); a2 = 5'(a);
            #1;
            n_cmp++;
            if (bus1.PEND_CNT !== 0 || bus1.BUSY1 !== 0 || bus0.BUSY2 !== 0
                || bus1.RD1 !== 0 || bus0.RD2 !== 0) begin
                n_bad++;
                $display("FAIL mid_reset_a%0d: cnt=%0d busy=%b rd=%h want 0",
                         a, bus1.PEND_CNT, bus1.BUSY1, bus1.RD1);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            we = $urandom_range(0, 1); rsv = $urandom_range(0, 2) == 0;
            a3 = 5'($urandom_range(0, 7)); ra = 5'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 7));
            wd3 = $urandom; be = 4'($urandom);
            #1;
            n_cmp++;
            if (bus1.RD1 !== exp_rd(a1, 1) || bus1.RD2 !== exp_rd(a2, 1)) begin
                n_bad++;
                $display("FAIL rnd_rd_byp c%0d: %h %h want %h %h", c,
                         bus1.RD1, bus1.RD2, exp_rd(a1, 1), exp_rd(a2, 1));
            end
            n_cmp++;
            if (bus0.RD1 !== exp_rd(a1, 0) || bus0.RD2 !== exp_rd(a2, 0)) begin
                n_bad++;
                $display("FAIL rnd_rd_nobyp c%0d: %h %h want %h %h", c,
                         bus0.RD1, bus0.RD2, exp_rd(a1, 0), exp_rd(a2, 0));
            end
            n_cmp++;
            if (bus1.BUSY1 !== exp_busy(a1, 1) || bus1.BUSY2 !== exp_busy(a2, 1)
                || bus0.BUSY1 !== exp_busy(a1, 0) || bus0.BUSY2 !== exp_busy(a2, 0)) begin
                n_bad++;
                $display("FAIL rnd_busy c%0d: %b%b/%b%b want %b%b/%b%b", c,
                         bus1.BUSY1, bus1.BUSY2, bus0.BUSY1, bus0.BUSY2,
                         exp_busy(a1, 1), exp_busy(a2, 1),
                         exp_busy(a1, 0), exp_busy(a2, 0));
            end
            n_cmp++;
            if (int'(bus1.PEND_CNT) != m_cnt() || int'(bus0.PEND_CNT) != m_cnt()) begin
                n_bad++;
                $display("FAIL rnd_cnt c%0d: %0d/%0d want %0d", c,
                         bus1.PEND_CNT, bus0.PEND_CNT, m_cnt());
            end
            tick();
        end
        rst = 0; idle();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_byte_write();
        test_bypass();
        test_zero_reg();
        test_pending();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
